// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// early stop-bit decision. Optional even parity via `define UART_RX_PARITY_EN.
module uart_rx_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SAMPLE_DIV = 1
) (
    input  logic                 sample_clk,
    input  logic                 rst,
    input  logic                 RsRx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int DW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MID = OVERSAMPLE / 2;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, rxd_q;
    logic [DW-1:0]        div_q, div_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dv_q, dv_d, fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d, pe_q, pe_d;
`endif

    logic rx_s, tick, vote, at_s0, at_s1, at_vote, at_end;

    assign rx_s    = sync2_q;
    assign tick    = (div_q == DW'(SAMPLE_DIV - 1));
    assign at_s0   = tick && (tick_cnt_q == TW'(MID - 1));
    assign at_s1   = tick && (tick_cnt_q == TW'(MID));
    assign at_vote = tick && (tick_cnt_q == TW'(MID + 1));
    assign at_end  = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));
    // Third sample is the live line at the vote tick, so no third storage flop.
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d    = state_q;
        div_d      = tick ? '0 : div_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        smp_d      = smp_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        dv_d       = 1'b0;
        fe_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        pe_d       = 1'b0;
`endif
        if (state_q != IDLE && tick) begin
            tick_cnt_d = at_end ? '0 : tick_cnt_q + 1'b1;
            if (at_s0) smp_d[0] = rx_s;
            if (at_s1) smp_d[1] = rx_s;
        end
        case (state_q)
            IDLE: begin
                // Edge-qualified start: a held-low break cannot retrigger.
                if (rxd_q && !rx_s) begin
                    state_d    = START;
                    div_d      = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (at_vote && vote) state_d = IDLE;
                else if (at_end)     state_d = DATA;
            end
            DATA: begin
                if (at_vote) begin
                    shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (at_end && bit_cnt_q == BW'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_vote) par_bad_d = (^shreg_q) ^ vote;
                if (at_end)  state_d   = STOP;
            end
`endif
            STOP: begin
                // Decide mid-bit and leave, so a start edge right after the stop is seen.
                if (at_vote) begin
                    state_d = IDLE;
                    fe_d    = !vote;
`ifdef UART_RX_PARITY_EN
                    dv_d    = vote && !par_bad_q;
                    pe_d    = par_bad_q;
`else
                    dv_d    = vote;
`endif
                    if (dv_d) dout_d = shreg_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rxd_q      <= 1'b1;
            div_q      <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
            shreg_q    <= '0;
            dout_q     <= '0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sync1_q    <= RsRx;
            sync2_q    <= sync1_q;
            rxd_q      <= sync2_q;
            div_q      <= div_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            smp_q      <= smp_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            dv_q       <= dv_d;
            fe_q       <= fe_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            pe_q       <= pe_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`endif
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler (8N1 at 16x, SAMPLE_DIV=1); parity frames
// are added when UART_RX_PARITY_EN is defined.
module tb_uart_rx_sampler;

    logic       sample_clk = 1'b0;
    logic       rst        = 1'b0;
    logic       RsRx       = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, busy, parity_err;

    always #5 sample_clk = ~sample_clk;

`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 2 + 16 * 10 + 9 + 1;
`else
    localparam int LAT_NOM = 2 + 16 * 9 + 9 + 1;
    assign parity_err = 1'b0;
`endif

    uart_rx_sampler #(.DATA_BITS(8), .OVERSAMPLE(16), .SAMPLE_DIV(1)) dut (
        .sample_clk (sample_clk),
        .rst        (rst),
        .RsRx       (RsRx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    // kind: 0 = data_valid, 1 = frame_err, 2 = parity_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        bit         lat;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, cyc = 0, last_fall = 0;

    always @(posedge sample_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input int kind, input logic [7:0] data, input bit lat);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.lat  = lat;
        q.push_back(e);
    endtask

    // Monitor: pop one expectation for every output pulse.
    always @(posedge sample_clk) begin : mon
        exp_t e;
        int   k, lat;
        #1;
        if (data_valid || frame_err || parity_err) begin
            k = data_valid ? 0 : (frame_err ? 1 : 2);
            chk("valid_ferr_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse kind=%0d data_out=%0h", k, data_out);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", k, e.kind);
                chk("data_out", {24'd0, data_out}, {24'd0, e.data});
                if (e.lat) begin
                    lat = cyc - last_fall;
                    total++;
                    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
                        bad++;
                        $display("FAIL latency actual=%0d required=%0d+-1", lat, LAT_NOM);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sample_clk);
            RsRx = 1'b1;
        end
    endtask

    // spike_bit: data bit index whose tick 8 is inverted for one clock (-1 = none).
    task automatic send_frame(input logic [7:0] d, input logic stopv, input int spike_bit,
                              input logic par_flip);
        logic [10:0] bits;
        int          nb;
`ifdef UART_RX_PARITY_EN
        bits = {stopv, (^d) ^ par_flip, d, 1'b0};
        nb   = 11;
`else
        bits = {par_flip, stopv, d, 1'b0};
        nb   = 10;
`endif
        for (int j = 0; j < nb; j++) begin
            for (int t = 0; t < 16; t++) begin
                @(negedge sample_clk);
                RsRx = bits[j] ^ ((j == spike_bit + 1) && (t == 8));
                if (j == 0 && t == 0) last_fall = cyc;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge sample_clk);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge sample_clk);
        rst = 1'b1;
        idle(5);

        push_exp(0, 8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        idle(20);

        // Short low glitch on an idle line must be rejected as a false start.
        repeat (6) begin
            @(negedge sample_clk);
            RsRx = 1'b0;
        end
        idle(16);
        chk("glitch_busy", {31'd0, busy}, 32'd0);

        // Bad stop bit, then hold the line low as a break.
        push_exp(1, 8'hA5, 1'b0);
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        repeat (40) begin
            @(negedge sample_clk);
            RsRx = 1'b0;
        end
        idle(30);

        push_exp(0, 8'h00, 1'b0);
        push_exp(0, 8'hFF, 1'b0);
        send_frame(8'h00, 1'b1, -1, 1'b0);
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        idle(20);

        push_exp(0, 8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 3, 1'b0);
        idle(20);

        // Abort a 0x81 frame during bit 4 with a 3-clock reset.
        for (int j = 0; j < 5; j++) begin
            for (int t = 0; t < ((j == 4) ? 8 : 16); t++) begin
                @(negedge sample_clk);
                RsRx = (j == 0) ? 1'b0 : ((j == 1) ? 1'b1 : 1'b0);
            end
        end
        rst  = 1'b0;
        RsRx = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_data_out", {24'd0, data_out}, 32'd0);
        repeat (3) @(negedge sample_clk);
        rst = 1'b1;
        idle(40);

        push_exp(0, 8'h81, 1'b0);
        send_frame(8'h81, 1'b1, -1, 1'b0);
        idle(20);

`ifdef UART_RX_PARITY_EN
        push_exp(2, 8'h81, 1'b0);
        send_frame(8'h81, 1'b1, -1, 1'b1);
        idle(20);
`endif

        idle(30);
        chk("pending_expectations", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
